// File: rtl/user_pkg.sv
// Shared widths, SRAM window base and lane typedefs for the block remapper and request-blocker lane.
package user_pkg;

    localparam int unsigned AddrWidth      = 32;
    localparam int unsigned BlockAddrWidth = 21;
    localparam int unsigned IdxWidth       = 3;
    localparam int unsigned DataWidth      = 32;
    localparam logic [AddrWidth-1:0] SramBase = 32'h1000_0000;

    typedef logic [BlockAddrWidth-1:0] blk_addr_t;
    typedef logic [IdxWidth-1:0]       blk_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        ISSUE,
        RESP
    } remap_state_e;

endpackage

// File: rtl/obi_block_remapper_cache.sv
// One-entry block-to-slot translation cache. A same-cycle invalidate beats an update.
module obi_block_remapper_cache #(
    parameter int unsigned BlockAddrWidth = user_pkg::BlockAddrWidth,
    parameter int unsigned IdxWidth       = user_pkg::IdxWidth
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [BlockAddrWidth-1:0] lookup_block_i,
    input  logic                      upd_i,
    input  logic [BlockAddrWidth-1:0] upd_block_i,
    input  logic [IdxWidth-1:0]       upd_idx_i,
    input  logic                      inval_i,
    output logic                      hit_o,
    output logic [IdxWidth-1:0]       hit_idx_o
);

    logic                      valid_q;
    logic [BlockAddrWidth-1:0] tag_q;
    logic [IdxWidth-1:0]       idx_q;

    // A swap in progress makes the cached slot untrustworthy even in this cycle.
    assign hit_o     = valid_q && (tag_q == lookup_block_i) && !inval_i;
    assign hit_idx_o = idx_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            idx_q   <= '0;
        end else if (inval_i) begin
            valid_q <= 1'b0;
        end else if (upd_i) begin
            valid_q <= 1'b1;
            tag_q   <= upd_block_i;
            idx_q   <= upd_idx_i;
        end
    end

endmodule

// File: rtl/obi_block_remapper.sv
// Translates core OBI block addresses into SRAM slot addresses via the request-blocker lane,
// with one outstanding transaction and a one-entry translation cache.
module obi_block_remapper #(
    parameter int unsigned AddrWidth      = user_pkg::AddrWidth,
    parameter int unsigned BlockAddrWidth = user_pkg::BlockAddrWidth,
    parameter int unsigned IdxWidth       = user_pkg::IdxWidth,
    parameter logic [AddrWidth-1:0] SramBase = user_pkg::SramBase,
    parameter int unsigned DataWidth      = user_pkg::DataWidth
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_req_i,
    output logic                      in_gnt_o,
    input  logic [AddrWidth-1:0]      in_addr_i,
    input  logic                      in_we_i,
    input  logic [DataWidth/8-1:0]    in_be_i,
    input  logic [DataWidth-1:0]      in_wdata_i,
    output logic                      in_rvalid_o,
    output logic [DataWidth-1:0]      in_rdata_o,
    output logic                      out_req_o,
    input  logic                      out_gnt_i,
    output logic [AddrWidth-1:0]      out_addr_o,
    output logic                      out_we_o,
    output logic [DataWidth/8-1:0]    out_be_o,
    output logic [DataWidth-1:0]      out_wdata_o,
    input  logic                      out_rvalid_i,
    input  logic [DataWidth-1:0]      out_rdata_i,
    output logic [BlockAddrWidth-1:0] blk_addr_o,
    output logic                      blk_valid_o,
    input  logic [IdxWidth-1:0]       blk_idx_i,
    input  logic                      blk_block_i
);

    localparam int unsigned OffW = AddrWidth - BlockAddrWidth;

    user_pkg::remap_state_e state_q, state_d;

    logic [AddrWidth-1:0]   addr_q;
    logic                   we_q;
    logic [DataWidth/8-1:0] be_q;
    logic [DataWidth-1:0]   wdata_q;
    logic [IdxWidth-1:0]    idx_q, idx_d;
    logic                   cache_upd;
    logic                   cache_hit;
    logic [IdxWidth-1:0]    cache_idx;
    logic                   capture;

    assign capture = (state_q == user_pkg::IDLE) && in_req_i;

    obi_block_remapper_cache #(
        .BlockAddrWidth (BlockAddrWidth),
        .IdxWidth       (IdxWidth)
    ) u_cache (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .lookup_block_i (in_addr_i[AddrWidth-1:OffW]),
        .upd_i          (cache_upd),
        .upd_block_i    (addr_q[AddrWidth-1:OffW]),
        .upd_idx_i      (blk_idx_i),
        .inval_i        (blk_block_i),
        .hit_o          (cache_hit),
        .hit_idx_o      (cache_idx)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cache_upd   = 1'b0;
        in_gnt_o    = 1'b0;
        in_rvalid_o = 1'b0;
        in_rdata_o  = '0;
        out_req_o   = 1'b0;
        out_addr_o  = '0;
        blk_valid_o = 1'b0;
        blk_addr_o  = '0;
        case (state_q)
            user_pkg::IDLE: begin
                if (in_req_i) begin
                    if (cache_hit) begin
                        idx_d   = cache_idx;
                        state_d = user_pkg::ISSUE;
                    end else begin
                        state_d = user_pkg::LOOKUP;
                    end
                end
            end
            user_pkg::LOOKUP: begin
                blk_valid_o = 1'b1;
                blk_addr_o  = addr_q[AddrWidth-1:OffW];
                if (!blk_block_i) begin
                    idx_d     = blk_idx_i;
                    cache_upd = 1'b1;
                    state_d   = user_pkg::ISSUE;
                end
            end
            user_pkg::ISSUE: begin
                out_req_o  = 1'b1;
                out_addr_o = SramBase + AddrWidth'({idx_q, addr_q[OffW-1:0]});
                if (out_gnt_i) begin
                    in_gnt_o = 1'b1;
                    state_d  = user_pkg::RESP;
                end
            end
            user_pkg::RESP: begin
                in_rvalid_o = out_rvalid_i;
                in_rdata_o  = out_rdata_i;
                if (out_rvalid_i) begin
                    state_d = user_pkg::IDLE;
                end
            end
            default: state_d = user_pkg::IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= user_pkg::IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (capture) begin
                addr_q  <= in_addr_i;
                we_q    <= in_we_i;
                be_q    <= in_be_i;
                wdata_q <= in_wdata_i;
            end
        end
    end

    assign out_we_o    = we_q;
    assign out_be_o    = be_q;
    assign out_wdata_o = wdata_q;

endmodule

// File: tb/tb_obi_block_remapper.sv
// Self-checking bench: directed vector table, reset corner cases, then randomized traffic vs. a cache model.
module tb_obi_block_remapper;

    localparam logic [31:0] SRAM_BASE = 32'h1000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_req_i;
    logic        in_gnt_o;
    logic [31:0] in_addr_i;
    logic        in_we_i;
    logic [3:0]  in_be_i;
    logic [31:0] in_wdata_i;
    logic        in_rvalid_o;
    logic [31:0] in_rdata_o;
    logic        out_req_o;
    logic        out_gnt_i;
    logic [31:0] out_addr_o;
    logic        out_we_o;
    logic [3:0]  out_be_o;
    logic [31:0] out_wdata_o;
    logic        out_rvalid_i;
    logic [31:0] out_rdata_i;
    logic [20:0] blk_addr_o;
    logic        blk_valid_o;
    logic [2:0]  blk_idx_i;
    logic        blk_block_i;

    int checks = 0;
    int errors = 0;

    obi_block_remapper dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .in_req_i     (in_req_i),
        .in_gnt_o     (in_gnt_o),
        .in_addr_i    (in_addr_i),
        .in_we_i      (in_we_i),
        .in_be_i      (in_be_i),
        .in_wdata_i   (in_wdata_i),
        .in_rvalid_o  (in_rvalid_o),
        .in_rdata_o   (in_rdata_o),
        .out_req_o    (out_req_o),
        .out_gnt_i    (out_gnt_i),
        .out_addr_o   (out_addr_o),
        .out_we_o     (out_we_o),
        .out_be_o     (out_be_o),
        .out_wdata_o  (out_wdata_o),
        .out_rvalid_i (out_rvalid_i),
        .out_rdata_i  (out_rdata_i),
        .blk_addr_o   (blk_addr_o),
        .blk_valid_o  (blk_valid_o),
        .blk_idx_i    (blk_idx_i),
        .blk_block_i  (blk_block_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          stall;
        logic [2:0]  idx;
        int          gnt_dly;
        int          rv_dly;
        logic        inval;
        logic        keep_req;
        logic        exp_hit;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[12];

    // Behavioural cache model for the random phase
    logic        m_valid;
    logic [20:0] m_tag;
    logic [2:0]  m_idx;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        in_req_i     = 1'b0;
        out_gnt_i    = 1'b0;
        out_rvalid_i = 1'b0;
        blk_block_i  = 1'b0;
    endtask

    task automatic check_quiet(input string nm);
        chk({nm, "_gnt"},    32'(in_gnt_o),    32'd0);
        chk({nm, "_rvalid"}, 32'(in_rvalid_o), 32'd0);
        chk({nm, "_rdata"},  in_rdata_o,       32'd0);
        chk({nm, "_req"},    32'(out_req_o),   32'd0);
        chk({nm, "_addr"},   out_addr_o,       32'd0);
        chk({nm, "_bvalid"}, 32'(blk_valid_o), 32'd0);
        chk({nm, "_baddr"},  32'(blk_addr_o),  32'd0);
    endtask

    task automatic do_txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                          input logic [31:0] wdata, input int stall, input logic [2:0] idx,
                          input int gnt_dly, input int rv_dly, input logic inval,
                          input logic keep_req, input logic exp_hit, input logic [31:0] exp_addr);
        logic [31:0] rdata;
        rdata = $urandom;
        @(negedge clk_i);
        idle_inputs();
        in_req_i     = 1'b1;
        in_addr_i    = addr;
        in_we_i      = we;
        in_be_i      = be;
        in_wdata_i   = wdata;
        out_rvalid_i = 1'($urandom);
        #1;
        chk("idle_gnt", 32'(in_gnt_o), 32'd0);
        chk("idle_bvalid", 32'(blk_valid_o), 32'd0);
        chk("idle_rvalid", 32'(in_rvalid_o), 32'd0);
        if (!exp_hit) begin
            for (int s = 0; s <= stall; s++) begin
                @(negedge clk_i);
                blk_block_i  = (s < stall);
                blk_idx_i    = (s < stall) ? 3'($urandom) : idx;
                out_rvalid_i = 1'($urandom);
                #1;
                chk("lookup_valid", 32'(blk_valid_o), 32'd1);
                chk("lookup_baddr", 32'(blk_addr_o), addr >> 11);
                chk("lookup_req", 32'(out_req_o), 32'd0);
                chk("lookup_rvalid", 32'(in_rvalid_o), 32'd0);
            end
        end
        for (int g = 0; g <= gnt_dly; g++) begin
            @(negedge clk_i);
            blk_block_i  = 1'b0;
            out_gnt_i    = (g == gnt_dly);
            out_rvalid_i = 1'($urandom);
            #1;
            chk("issue_req", 32'(out_req_o), 32'd1);
            chk("issue_addr", out_addr_o, exp_addr);
            chk("issue_we", 32'(out_we_o), 32'(we));
            chk("issue_be", 32'(out_be_o), 32'(be));
            chk("issue_wdata", out_wdata_o, wdata);
            chk("issue_gnt", 32'(in_gnt_o), 32'(out_gnt_i));
            chk("issue_bvalid", 32'(blk_valid_o), 32'd0);
            chk("issue_rvalid", 32'(in_rvalid_o), 32'd0);
        end
        for (int r = 0; r <= rv_dly; r++) begin
            @(negedge clk_i);
            out_gnt_i    = 1'b0;
            in_req_i     = keep_req;
            blk_block_i  = inval && (r == 0);
            out_rvalid_i = (r == rv_dly);
            out_rdata_i  = (r == rv_dly) ? rdata : $urandom;
            #1;
            chk("resp_rvalid", 32'(in_rvalid_o), 32'(out_rvalid_i));
            chk("resp_gnt", 32'(in_gnt_o), 32'd0);
            chk("resp_req", 32'(out_req_o), 32'd0);
            if (r == rv_dly) chk("resp_rdata", in_rdata_o, rdata);
        end
    endtask

    initial begin
        logic [20:0] blocks[4];
        logic [2:0]  idx_map[4];

        idle_inputs();
        in_addr_i   = '0;
        in_we_i     = 1'b0;
        in_be_i     = '0;
        in_wdata_i  = '0;
        out_rdata_i = '0;
        blk_idx_i   = '0;
        rst_i       = 1'b1;

        vecs[0]  = '{32'h1000_0804, 1'b0, 4'hF, 32'h0,         0, 3'd3, 0, 0, 1'b0, 1'b0, 1'b0, 32'h1000_1804};
        vecs[1]  = '{32'h1000_0810, 1'b0, 4'hF, 32'h0,         0, 3'd0, 0, 0, 1'b0, 1'b0, 1'b1, 32'h1000_1810};
        vecs[2]  = '{32'h2000_0040, 1'b0, 4'hF, 32'h0,         5, 3'd6, 0, 0, 1'b0, 1'b0, 1'b0, 32'h1000_3040};
        vecs[3]  = '{32'h2000_0044, 1'b0, 4'hF, 32'h0,         0, 3'd0, 0, 0, 1'b0, 1'b0, 1'b1, 32'h1000_3044};
        vecs[4]  = '{32'h2000_0100, 1'b1, 4'h6, 32'hDEAD_BEEF, 0, 3'd0, 3, 0, 1'b0, 1'b0, 1'b1, 32'h1000_3100};
        vecs[5]  = '{32'h2000_0200, 1'b0, 4'hF, 32'h0,         0, 3'd0, 0, 4, 1'b0, 1'b1, 1'b1, 32'h1000_3200};
        vecs[6]  = '{32'h1000_0808, 1'b0, 4'hF, 32'h0,         0, 3'd3, 0, 4, 1'b0, 1'b1, 1'b0, 32'h1000_1808};
        vecs[7]  = '{32'h1000_080C, 1'b0, 4'hF, 32'h0,         0, 3'd0, 0, 2, 1'b1, 1'b0, 1'b1, 32'h1000_180C};
        vecs[8]  = '{32'h1000_0810, 1'b0, 4'hF, 32'h0,         0, 3'd5, 0, 0, 1'b0, 1'b0, 1'b0, 32'h1000_2810};
        vecs[9]  = '{32'hFFFF_FFFF, 1'b0, 4'hF, 32'h0,         0, 3'd7, 1, 1, 1'b0, 1'b0, 1'b0, 32'h1000_3FFF};
        vecs[10] = '{32'h0000_0000, 1'b1, 4'hF, 32'h1234_5678, 0, 3'd0, 0, 0, 1'b0, 1'b0, 1'b0, 32'h1000_0000};
        vecs[11] = '{32'h0000_07FC, 1'b0, 4'hF, 32'h0,         0, 3'd0, 0, 0, 1'b0, 1'b0, 1'b1, 32'h1000_07FC};

        #12;
        check_quiet("reset");
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check_quiet("post_reset");

        for (int i = 0; i < 12; i++) begin
            do_txn(vecs[i].addr, vecs[i].we, vecs[i].be, vecs[i].wdata, vecs[i].stall,
                   vecs[i].idx, vecs[i].gnt_dly, vecs[i].rv_dly, vecs[i].inval,
                   vecs[i].keep_req, vecs[i].exp_hit, vecs[i].exp_addr);
        end

        // Reset while in LOOKUP: outputs drop at once, and block 0 is no longer cached
        @(negedge clk_i);
        idle_inputs();
        in_req_i  = 1'b1;
        in_addr_i = 32'h1000_0804;
        @(negedge clk_i);
        blk_idx_i = 3'd4;
        #1;
        chk("rstA_lookup", 32'(blk_valid_o), 32'd1);
        #1;
        rst_i = 1'b1;
        #1;
        check_quiet("rstA");
        @(negedge clk_i);
        rst_i    = 1'b0;
        in_req_i = 1'b0;
        do_txn(32'h0000_0010, 1'b0, 4'hF, 32'h0, 0, 3'd2, 0, 0, 1'b0, 1'b0, 1'b0, 32'h1000_1010);

        // Reset while in RESP: a response arriving after reset must be dropped
        @(negedge clk_i);
        idle_inputs();
        in_req_i  = 1'b1;
        in_addr_i = 32'h0000_0014;
        @(negedge clk_i);
        out_gnt_i = 1'b1;
        #1;
        chk("rstB_hit_addr", out_addr_o, 32'h1000_1014);
        chk("rstB_gnt", 32'(in_gnt_o), 32'd1);
        @(negedge clk_i);
        out_gnt_i = 1'b0;
        in_req_i  = 1'b0;
        #1;
        rst_i = 1'b1;
        out_rvalid_i = 1'b1;
        out_rdata_i  = 32'hCAFE_F00D;
        #1;
        check_quiet("rstB");
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("rstB_late_rvalid", 32'(in_rvalid_o), 32'd0);
        do_txn(32'h0000_0018, 1'b0, 4'hF, 32'h0, 0, 3'd1, 0, 0, 1'b0, 1'b0, 1'b0, 32'h1000_0818);

        // Random phase, from a clean reset so the model starts with an empty cache
        @(negedge clk_i);
        idle_inputs();
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i   = 1'b0;
        m_valid = 1'b0;
        m_tag   = '0;
        m_idx   = '0;
        for (int k = 0; k < 4; k++) begin
            blocks[k]  = 21'($urandom);
            idx_map[k] = 3'($urandom);
        end
        for (int t = 0; t < 60; t++) begin
            int          k;
            int          stall;
            logic [10:0] off;
            logic [31:0] addr;
            logic        hit;
            logic        inval;
            logic [2:0]  idx;
            k     = $urandom_range(0, 3);
            off   = 11'($urandom);
            addr  = {blocks[k], off};
            hit   = m_valid && (m_tag == blocks[k]);
            stall = hit ? 0 : $urandom_range(0, 3);
            if (!hit && stall > 0 && $urandom_range(0, 1) == 1) idx_map[k] = 3'($urandom);
            idx   = hit ? m_idx : idx_map[k];
            inval = ($urandom_range(0, 4) == 0);
            do_txn(addr, 1'($urandom), 4'($urandom), $urandom, stall, idx_map[k],
                   $urandom_range(0, 2), $urandom_range(0, 3), inval, 1'($urandom),
                   hit, SRAM_BASE + 32'(idx) * 32'd2048 + 32'(off));
            if (!hit) begin
                m_valid = 1'b1;
                m_tag   = blocks[k];
                m_idx   = idx;
            end
            if (inval) m_valid = 1'b0;
        end

        @(negedge clk_i);
        idle_inputs();
        #1;
        check_quiet("final_idle");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
